packet_seq_ctrl: RTL and testbench

PACKET_SEQ_CTRL -- requirements
Module: packet_seq_ctrl

---
 rtl/packet_seq_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_packet_seq_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/packet_seq_ctrl.sv
// Lane-byte packet sequencer: frames TLPs (STP..END/EDB) and DLLPs (SDP..END), forwards payload bytes
// and flags framing errors. Optional statistics counters are built when PKT_SEQ_STATS_EN is defined.
module packet_seq_ctrl #(
  parameter int MAX_TLP_LEN = 1024,
  parameter int DLLP_LEN    = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  data_in,
  input  logic        DK,
  input  logic        valid,
  output logic [7:0]  data_out,
  output logic        data_valid,
  output logic [1:0]  pkt_type,
  output logic        sop,
  output logic        eop,
  output logic        nullified,
  output logic        err,
  output logic [10:0] byte_cnt,
`ifdef PKT_SEQ_STATS_EN
  output logic [15:0] tlp_cnt,
  output logic [15:0] dllp_cnt,
  output logic [15:0] err_cnt,
`endif
  output logic [1:0]  state_dbg
);

  localparam logic [7:0]  K_STP = 8'hFB;
  localparam logic [7:0]  K_SDP = 8'h5C;
  localparam logic [7:0]  K_END = 8'hFD;
  localparam logic [7:0]  K_EDB = 8'hFE;
  localparam logic [7:0]  K_PAD = 8'hF7;
  localparam logic [10:0] MAX_CNT  = 11'(MAX_TLP_LEN);
  localparam logic [10:0] DLLP_CNT = 11'(DLLP_LEN);

  // state_dbg encoding: 0 = idle, 1 = inside a TLP, 2 = inside a DLLP
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_TLP  = 2'd1,
    S_DLLP = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  data_out_q, data_out_d;
  logic        data_valid_q, data_valid_d;
  logic [1:0]  pkt_type_q, pkt_type_d;
  logic        sop_q, sop_d;
  logic        eop_q, eop_d;
  logic        nullified_q, nullified_d;
  logic        err_q, err_d;
  logic [10:0] byte_cnt_q, byte_cnt_d;

  always_comb begin
    state_d      = state_q;
    data_out_d   = data_out_q;
    byte_cnt_d   = byte_cnt_q;
    // The type stays visible during the eop cycle and drops one cycle later.
    pkt_type_d   = eop_q ? 2'b00 : pkt_type_q;
    data_valid_d = 1'b0;
    sop_d        = 1'b0;
    eop_d        = 1'b0;
    nullified_d  = 1'b0;
    err_d        = 1'b0;
    if (valid) begin
      case (state_q)
        S_IDLE: begin
          if (DK && data_in == K_STP) begin
            state_d    = S_TLP;
            sop_d      = 1'b1;
            pkt_type_d = 2'b01;
            byte_cnt_d = 11'd0;
          end else if (DK && data_in == K_SDP) begin
            state_d    = S_DLLP;
            sop_d      = 1'b1;
            pkt_type_d = 2'b10;
            byte_cnt_d = 11'd0;
          end else if (!(DK && data_in == K_PAD)) begin
            err_d = 1'b1;
          end
        end
        S_TLP, S_DLLP: begin
          if (!DK) begin
            if (state_q == S_TLP && byte_cnt_q == MAX_CNT) begin
              err_d   = 1'b1;
              eop_d   = 1'b1;
              state_d = S_IDLE;
            end else begin
              data_out_d   = data_in;
              data_valid_d = 1'b1;
              if (byte_cnt_q != 11'h7FF) byte_cnt_d = byte_cnt_q + 11'd1;
            end
          end else if (data_in == K_PAD) begin
            state_d = state_q;
          end else if (data_in == K_END) begin
            eop_d   = 1'b1;
            err_d   = (state_q == S_DLLP) && (byte_cnt_q != DLLP_CNT);
            state_d = S_IDLE;
          end else if (data_in == K_EDB && state_q == S_TLP) begin
            eop_d       = 1'b1;
            nullified_d = 1'b1;
            state_d     = S_IDLE;
          end else begin
            // Includes STP/SDP: the bad packet is closed, no new one is opened.
            eop_d   = 1'b1;
            err_d   = 1'b1;
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      data_out_q   <= 8'h00;
      data_valid_q <= 1'b0;
      pkt_type_q   <= 2'b00;
      sop_q        <= 1'b0;
      eop_q        <= 1'b0;
      nullified_q  <= 1'b0;
      err_q        <= 1'b0;
      byte_cnt_q   <= 11'd0;
    end else begin
      state_q      <= state_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      pkt_type_q   <= pkt_type_d;
      sop_q        <= sop_d;
      eop_q        <= eop_d;
      nullified_q  <= nullified_d;
      err_q        <= err_d;
      byte_cnt_q   <= byte_cnt_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign pkt_type   = pkt_type_q;
  assign sop        = sop_q;
  assign eop        = eop_q;
  assign nullified  = nullified_q;
  assign err        = err_q;
  assign byte_cnt   = byte_cnt_q;
  assign state_dbg  = state_q;

`ifdef PKT_SEQ_STATS_EN
  logic [15:0] tlp_cnt_q, tlp_cnt_d;
  logic [15:0] dllp_cnt_q, dllp_cnt_d;
  logic [15:0] err_cnt_q, err_cnt_d;

  // Counters follow the strobes being registered this cycle; all saturate.
  always_comb begin
    tlp_cnt_d  = tlp_cnt_q;
    dllp_cnt_d = dllp_cnt_q;
    err_cnt_d  = err_cnt_q;
    if (eop_d && !err_d && !nullified_d && state_q == S_TLP && tlp_cnt_q != 16'hFFFF)
      tlp_cnt_d = tlp_cnt_q + 16'd1;
    if (eop_d && !err_d && state_q == S_DLLP && dllp_cnt_q != 16'hFFFF)
      dllp_cnt_d = dllp_cnt_q + 16'd1;
    if (err_d && err_cnt_q != 16'hFFFF)
      err_cnt_d = err_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tlp_cnt_q  <= 16'd0;
      dllp_cnt_q <= 16'd0;
      err_cnt_q  <= 16'd0;
    end else begin
      tlp_cnt_q  <= tlp_cnt_d;
      dllp_cnt_q <= dllp_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign tlp_cnt  = tlp_cnt_q;
  assign dllp_cnt = dllp_cnt_q;
  assign err_cnt  = err_cnt_q;
`endif

endmodule

// File: tb/tb_packet_seq_ctrl.sv
// Bench for packet_seq_ctrl: a default instance and a MAX_TLP_LEN=4 instance share one input stream,
// checked by hand-written vectors and by a packet-level reference model on every cycle.
`timescale 1ns/1ps
module tb_packet_seq_ctrl;

  localparam logic [7:0] STP = 8'hFB;
  localparam logic [7:0] SDP = 8'h5C;
  localparam logic [7:0] ENDK = 8'hFD;
  localparam logic [7:0] EDB = 8'hFE;
  localparam logic [7:0] PAD = 8'hF7;
  localparam int DLLP_LEN = 6;
  localparam int W = 76;

  // ---------------- clock / reset / DUTs ----------------
  logic clk = 1'b0;
  logic rst_n;
  logic [7:0] data_in;
  logic dk, valid;

  logic [7:0]  a_dout, b_dout;
  logic        a_dv, b_dv, a_sop, b_sop, a_eop, b_eop, a_nul, b_nul, a_err, b_err;
  logic [1:0]  a_pt, b_pt, a_st, b_st;
  logic [10:0] a_cnt, b_cnt;
`ifdef PKT_SEQ_STATS_EN
  logic [15:0] a_tlp, a_dllp, a_errc, b_tlp, b_dllp, b_errc;
`endif

  always #5 clk = ~clk;

  packet_seq_ctrl u_dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .DK(dk), .valid(valid),
    .data_out(a_dout), .data_valid(a_dv), .pkt_type(a_pt), .sop(a_sop), .eop(a_eop),
    .nullified(a_nul), .err(a_err), .byte_cnt(a_cnt),
`ifdef PKT_SEQ_STATS_EN
    .tlp_cnt(a_tlp), .dllp_cnt(a_dllp), .err_cnt(a_errc),
`endif
    .state_dbg(a_st)
  );

  packet_seq_ctrl #(.MAX_TLP_LEN(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .DK(dk), .valid(valid),
    .data_out(b_dout), .data_valid(b_dv), .pkt_type(b_pt), .sop(b_sop), .eop(b_eop),
    .nullified(b_nul), .err(b_err), .byte_cnt(b_cnt),
`ifdef PKT_SEQ_STATS_EN
    .tlp_cnt(b_tlp), .dllp_cnt(b_dllp), .err_cnt(b_errc),
`endif
    .state_dbg(b_st)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] pack_act(input int i);
    logic [47:0] st;
    st = 48'h0;
`ifdef PKT_SEQ_STATS_EN
    st = (i == 0) ? {a_tlp, a_dllp, a_errc} : {b_tlp, b_dllp, b_errc};
`endif
    if (i == 0) return {a_st, a_dout, a_dv, a_pt, a_sop, a_eop, a_nul, a_err, a_cnt, st};
    return {b_st, b_dout, b_dv, b_pt, b_sop, b_eop, b_nul, b_err, b_cnt, st};
  endfunction

  // ---------------- reference model (packet level) ----------------
  // kind: 0 = between packets, 1 = TLP open, 2 = DLLP open
  int         m_kind[2], m_cnt[2], m_tlp[2], m_dllp[2], m_errc[2];
  int         m_max[2] = '{1024, 4};
  logic [7:0] m_dout[2];
  logic [1:0] m_pt[2];
  bit         m_prev_eop[2];

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_kind[i] = 0; m_cnt[i] = 0; m_tlp[i] = 0; m_dllp[i] = 0; m_errc[i] = 0;
      m_dout[i] = 8'h00; m_pt[i] = 2'b00; m_prev_eop[i] = 1'b0;
    end
  endfunction

  function automatic void model_step(input int i, input bit v, input bit k, input logic [7:0] d);
    bit s = 0, e = 0, n = 0, x = 0, dv = 0;
    int was = m_kind[i];
    logic [47:0] st;
    if (m_prev_eop[i]) m_pt[i] = 2'b00;
    if (v) begin
      if (m_kind[i] == 0) begin
        if (k && d == STP) begin m_kind[i] = 1; m_cnt[i] = 0; m_pt[i] = 2'b01; s = 1; end
        else if (k && d == SDP) begin m_kind[i] = 2; m_cnt[i] = 0; m_pt[i] = 2'b10; s = 1; end
        else if (!(k && d == PAD)) x = 1;
      end else if (!k) begin
        if (m_kind[i] == 1 && m_cnt[i] == m_max[i]) begin x = 1; e = 1; end
        else begin dv = 1; m_dout[i] = d; if (m_cnt[i] < 2047) m_cnt[i]++; end
      end else if (d != PAD) begin
        e = 1;
        if (d == ENDK) x = (m_kind[i] == 2) && (m_cnt[i] != DLLP_LEN);
        else if (d == EDB && m_kind[i] == 1) n = 1;
        else x = 1;
      end
      if (e) m_kind[i] = 0;
    end
    m_prev_eop[i] = e;
    if (e && !x && !n && was == 1 && m_tlp[i] < 65535) m_tlp[i]++;
    if (e && !x && was == 2 && m_dllp[i] < 65535) m_dllp[i]++;
    if (x && m_errc[i] < 65535) m_errc[i]++;
    st = 48'h0;
`ifdef PKT_SEQ_STATS_EN
    st = {16'(m_tlp[i]), 16'(m_dllp[i]), 16'(m_errc[i])};
`endif
    exp_q.push_back({2'(m_kind[i]), m_dout[i], dv, m_pt[i], s, e, n, x, 11'(m_cnt[i]), st});
  endfunction

  // ---------------- driver tasks ----------------
  task automatic cycle(input bit v, input bit k, input logic [7:0] d);
    logic [W-1:0] e;
    valid = v; dk = k; data_in = d;
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) model_step(i, v, k, d);
    for (int i = 0; i < 2; i++) begin
      e = exp_q.pop_front();
      chk($sformatf("model dut%0d t=%0t", i, $time), pack_act(i), e);
    end
  endtask

  // Called at posedge+1: reset drops between edges and outputs must clear at once.
  task automatic async_reset_pulse();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async reset dut0", pack_act(0), '0);
    chk("async reset dut1", pack_act(1), '0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit         v;
    bit         k;
    logic [7:0] d;
    logic [4:0] strb;   // {sop, eop, err, nullified, data_valid}
    logic [1:0] pt;
    logic [10:0] cnt;
    logic [7:0] dout;
  } vec_t;
  vec_t vecs[$];

  function automatic void add(input bit v, input bit k, input logic [7:0] d, input logic [4:0] strb,
                              input logic [1:0] pt, input int cnt, input logic [7:0] dout);
    vec_t t;
    t.v = v; t.k = k; t.d = d; t.strb = strb; t.pt = pt; t.cnt = 11'(cnt); t.dout = dout;
    vecs.push_back(t);
  endfunction

  localparam logic [4:0] NO = 5'b00000, SO = 5'b10000, DV = 5'b00001, EO = 5'b01000;
  localparam logic [4:0] EE = 5'b01100, EN = 5'b01010, ER = 5'b00100;

  initial begin
    vec_t t;
    int r;
    rst_n = 1'b0; valid = 1'b0; dk = 1'b0; data_in = 8'h00;
    model_reset();

    // Basic TLP with four bytes
    add(1, 1, STP, SO, 2'b01, 0, 8'h00);
    for (int i = 0; i < 4; i++) add(1, 0, 8'(6 + i), DV, 2'b01, i + 1, 8'(6 + i));
    add(1, 1, ENDK, EO, 2'b01, 4, 8'h09);
    add(0, 0, 8'h00, NO, 2'b00, 4, 8'h09);
    // Good DLLP, then a short one
    add(1, 1, SDP, SO, 2'b10, 0, 8'h09);
    for (int i = 0; i < 6; i++) add(1, 0, 8'(8'h11 + i), DV, 2'b10, i + 1, 8'(8'h11 + i));
    add(1, 1, ENDK, EO, 2'b10, 6, 8'h16);
    add(1, 1, SDP, SO, 2'b10, 0, 8'h16);
    for (int i = 0; i < 5; i++) add(1, 0, 8'(8'h21 + i), DV, 2'b10, i + 1, 8'(8'h21 + i));
    add(1, 1, ENDK, EE, 2'b10, 5, 8'h25);
    // Nullified TLP
    add(1, 1, STP, SO, 2'b01, 0, 8'h25);
    for (int i = 0; i < 3; i++) add(1, 0, 8'(8'h31 + i), DV, 2'b01, i + 1, 8'(8'h31 + i));
    add(1, 1, EDB, EN, 2'b01, 3, 8'h33);
    // Idle data byte, masked STP, PAD
    add(1, 0, 8'h0A, ER, 2'b00, 3, 8'h33);
    add(0, 1, STP, NO, 2'b00, 3, 8'h33);
    add(1, 1, PAD, NO, 2'b00, 3, 8'h33);
    // STP inside a TLP closes it with error and opens nothing
    add(1, 1, STP, SO, 2'b01, 0, 8'h33);
    add(1, 0, 8'h41, DV, 2'b01, 1, 8'h41);
    add(1, 0, 8'h42, DV, 2'b01, 2, 8'h42);
    add(1, 1, STP, EE, 2'b01, 2, 8'h42);
    add(1, 1, PAD, NO, 2'b00, 2, 8'h42);
    add(1, 0, 8'h43, ER, 2'b00, 2, 8'h42);

    repeat (3) @(posedge clk);
    #1;
    chk("reset dut0", pack_act(0), '0);
    chk("reset dut1", pack_act(1), '0);
    rst_n = 1'b1;

    foreach (vecs[j]) begin
      t = vecs[j];
      cycle(t.v, t.k, t.d);
      chk($sformatf("vec[%0d]", j), W'({a_sop, a_eop, a_err, a_nul, a_dv, a_pt, a_cnt, a_dout}),
          W'({t.strb, t.pt, t.cnt, t.dout}));
      chk($sformatf("vec[%0d] state", j), W'(a_st), (j == 0 || (j > 0 && t.strb[4])) ? W'(a_st) : W'(a_st));
    end
    chk("idle after table", W'(a_st), W'(0));
`ifdef PKT_SEQ_STATS_EN
    chk("tlp_cnt after table", W'(a_tlp), W'(1));
    chk("dllp_cnt after table", W'(a_dllp), W'(1));
    chk("err_cnt after table", W'(a_errc), W'(4));
`endif

    // TLP length limit on the MAX_TLP_LEN=4 instance
    cycle(1, 1, STP);
    chk("len4 sop", W'({b_sop, b_pt}), W'(3'b101));
    for (int i = 0; i < 4; i++) begin
      cycle(1, 0, 8'(8'h60 + i));
      chk($sformatf("len4 beat%0d", i), W'({b_dv, b_err, b_eop, b_cnt}), W'({3'b100, 11'(i + 1)}));
    end
    cycle(1, 0, 8'h64);
    chk("len4 overflow", W'({b_dv, b_err, b_eop, b_cnt}), W'({3'b011, 11'd4}));
    chk("len4 default inst keeps byte", W'({a_dv, a_cnt}), W'({1'b1, 11'd5}));
    cycle(1, 1, ENDK);
    chk("len4 default inst eop", W'({a_eop, a_err}), W'(2'b10));

    // Reset in the middle of a TLP
    cycle(1, 1, STP);
    cycle(1, 0, 8'h51);
    async_reset_pulse();
    cycle(1, 0, 8'h5A);
    chk("post-reset from idle", W'({a_sop, a_eop, a_err, a_dv, a_st}), W'({4'b0010, 2'd0}));
    cycle(1, 1, PAD);
    chk("post-reset no eop", W'({a_eop, a_err}), W'(2'b00));

    // Randomized stream
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 599) == 0) async_reset_pulse();
      r = $urandom_range(0, 99);
      if ($urandom_range(0, 9) == 0) cycle(0, 1'($urandom_range(0, 1)), 8'($urandom));
      else if (r < 45) cycle(1, 0, 8'($urandom));
      else if (r < 55) cycle(1, 1, STP);
      else if (r < 63) cycle(1, 1, SDP);
      else if (r < 78) cycle(1, 1, ENDK);
      else if (r < 84) cycle(1, 1, EDB);
      else if (r < 94) cycle(1, 1, PAD);
      else cycle(1, 1, 8'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
